priority_arbiter_ctrl: RTL and testbench
========================================

// Module: priority_arbiter_ctrl
// PURPOSE
//  Sequencing arbiter that shares one resource among N requesters using 8:3 priority encoding.
//  Grants are registered and held until the owner releases, drops its request, or times out.
//  Supports fixed priority (highest index wins) and round-robin. Sits between request sources
//  and the shared datapath; gnt_id drives the resource mux select.
// PARAMETERS
//  N       8    number of requesters (ID_W = $clog2(N))
//  TIMEOUT 16   max consecutive GRANT cycles per grant; 0 = timeout disabled
// PORTS
//  clk       in   1     clock, rising edge
//  rst_n     in   1     reset, asynchronous assert, active-low
//  req       in   N     request vector, level, held until served
//  done      in   1     current owner finished; sampled only in GRANT
//  rr_mode   in   1     0 = fixed priority, 1 = round-robin; sampled only at arbitration
//  gnt       out  N     one-hot grant, all-zero when no owner
//  gnt_id    out  ID_W  index of current owner; holds last value when gnt_valid=0
//  gnt_valid out  1     high while a grant is active (= |gnt)
//  timeout   out  1     one-cycle pulse when a grant is revoked by TIMEOUT
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE, last_id=0, hold_cnt=0.
//  All outputs are registered; no combinational path from req/done to outputs.
//  States: IDLE, GRANT, GAP.
//   IDLE:  if |req, arbitrate -> GRANT next cycle (req-to-gnt latency 1 clk); else stay.
//   GRANT: gnt[gnt_id]=1; hold_cnt increments each cycle starting at 1 on the first GRANT cycle.
//     Exit to GAP when any of these hold: done=1, req[gnt_id]=0, or (TIMEOUT!=0 and hold_cnt==TIMEOUT).
//     On exit: last_id<=gnt_id, gnt<=0, gnt_valid<=0, hold_cnt<=0.
//     timeout<=1 on the exit edge only if the exit is due to the count alone
//     (done=0 and req[gnt_id]=1).
//   GAP:   one mandatory idle cycle, gnt=0 (resource turnaround); timeout clears to 0.
//     If |req: arbitrate -> GRANT. Else -> IDLE.
//  Arbitration (combinational on req, registered into gnt/gnt_id):
//   fixed (rr_mode=0): highest set index of req wins (req[N-1] highest, req[0] lowest).
//   round-robin (rr_mode=1): search from index last_id-1 downward, wrapping N-1 after 0.
//     The search ends at last_id itself. last_id=0 after reset, so the first RR grant equals fixed order.
//  Max hold: gnt asserted for at most TIMEOUT consecutive cycles.
//  done=1 and count expiry in the same cycle: done wins; release without timeout pulse.
//  done or req changes in IDLE/GAP: no effect on state; done is ignored outside GRANT.
//  Requests from non-owners during GRANT do not pre-empt; they are considered at the next arbitration.
//  Same requester still requesting after release: eligible again after GAP.
//   In RR mode it has the lowest priority.
//  hold_cnt width $clog2(TIMEOUT+1); it never wraps because it is cleared on exit.
//  rst_n low mid-grant: gnt, gnt_valid and timeout drop immediately (asynchronously); FSM returns to IDLE.
// TESTING
//  1 reset, rr_mode=0, req=8'b0010_0100 -> 1 clk later gnt=8'b0010_0000, gnt_id=5, gnt_valid=1.
//  2 from test 1, done pulse 1 clk -> next clk gnt=0 (GAP), following clk gnt=8'b0000_0100, gnt_id=2.
//  3 rr_mode=1, req=8'hFF held, done pulsed each grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7;
//    one GAP cycle between grants.
//  4 TIMEOUT=4, req=8'b0000_1000 held, no done -> gnt_valid high exactly 4 clks, then timeout=1 for 1 clk
//    with gnt=0, then regrant id=3.
//  5 owner id=6 drops req[6] mid-grant while done=0 -> release next clk, timeout stays 0.
//    done together with count expiry -> timeout stays 0.
//  6 rst_n=0 asserted mid-GRANT between clock edges -> gnt=0, gnt_valid=0 immediately.
//    After release, with req=8'b1000_0001 and rr_mode=1, gnt_id=7 first.

Source files
------------

// File: rtl/priority_arbiter_ctrl.sv
// Shares one resource among N requesters. Grants are registered and held until
// the owner releases. Fixed priority (highest index wins) or round-robin after last owner.
module priority_arbiter_ctrl #(
  parameter  int N       = 8,
  parameter  int TIMEOUT = 16,
  localparam int ID_W    = (N > 1) ? $clog2(N) : 1,
  localparam int HC_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  input  logic            rr_mode,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [ID_W-1:0]   fix_id, rr_id, win_id;
  logic              owner_req, expire;

  // Ascending scans: the last hit is the highest index / first index along the RR search.
  always_comb begin
    fix_id = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) fix_id = ID_W'(i);
    rr_id = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(last_id_q) + N - k) % N;
      if (req[idx]) rr_id = ID_W'(idx);
    end
    win_id = rr_mode ? rr_id : fix_id;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_id_d   = last_id_q;
    hold_cnt_d  = hold_cnt_q;
    owner_req   = req[gnt_id_q];
    expire      = (TIMEOUT != 0) && (hold_cnt_q == HC_W'(TIMEOUT));
    case (state_q)
      S_IDLE, S_GAP: begin
        if (|req) begin
          state_d     = S_GRANT;
          gnt_id_d    = win_id;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = HC_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (done || !owner_req || expire) begin
          state_d     = S_GAP;
          last_id_d   = gnt_id_q;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // Only the count can be the cause here; done wins over expiry.
          timeout_d   = !done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_id_q   <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_id_q   <= last_id_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
// Directed bench for priority_arbiter_ctrl (N=8, TIMEOUT=4) with hand-computed expectations.
module tb_priority_arbiter_ctrl;
  logic       clk, rst_n, done, rr_mode;
  logic [7:0] req, gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, timeout;
  int         n_run = 0, n_fail = 0;

  priority_arbiter_ctrl #(.N(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_id", 32'(gnt_id), 0);
    chk("rst_vld", 32'(gnt_valid), 0);
    chk("rst_to", 32'(timeout), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_ids[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rr_mode = 1'b0;
    do_reset();

    // 1: fixed priority picks highest index, one-cycle latency
    req = 8'b0010_0100;
    chk("t1_pre_vld", 32'(gnt_valid), 0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h20);
    chk("t1_id", 32'(gnt_id), 5);
    chk("t1_vld", 32'(gnt_valid), 1);

    // 2: done releases, GAP cycle, then next requester
    done = 1'b1; req = 8'b0000_0100;
    tick();
    done = 1'b0;
    chk("t2_gap_gnt", 32'(gnt), 0);
    chk("t2_gap_vld", 32'(gnt_valid), 0);
    chk("t2_gap_id_hold", 32'(gnt_id), 5);
    chk("t2_gap_to", 32'(timeout), 0);
    tick();
    chk("t2_gnt", 32'(gnt), 32'h04);
    chk("t2_id", 32'(gnt_id), 2);
    req = '0;
    tick(); tick();
    chk("t2_idle_vld", 32'(gnt_valid), 0);

    // 3: round-robin sweep from reset state
    do_reset();
    rr_mode = 1'b1; req = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      chk("t3_id", 32'(gnt_id), 32'(exp_ids[g]));
      chk("t3_gnt", 32'(gnt), 32'(8'h01 << exp_ids[g]));
      done = 1'b1;
      if (g == 8) req = '0;
      tick();
      done = 1'b0;
      chk("t3_gap_vld", 32'(gnt_valid), 0);
      tick();
    end
    chk("t3_idle_vld", 32'(gnt_valid), 0);

    // 4: timeout after 4 grant cycles, pulse in GAP, regrant
    rr_mode = 1'b0; req = 8'b0000_1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_vld", 32'(gnt_valid), 1);
      chk("t4_to_low", 32'(timeout), 0);
    end
    tick();
    chk("t4_exp_gnt", 32'(gnt), 0);
    chk("t4_exp_to", 32'(timeout), 1);
    tick();
    chk("t4_regnt_id", 32'(gnt_id), 3);
    chk("t4_regnt_vld", 32'(gnt_valid), 1);
    chk("t4_to_clr", 32'(timeout), 0);
    req = '0;
    tick();
    chk("t4_drop_to", 32'(timeout), 0);
    tick();

    // 5a: owner drops request mid-grant
    req = 8'b0100_0000;
    tick();
    chk("t5_id", 32'(gnt_id), 6);
    tick();
    req = '0;
    tick();
    chk("t5_drop_gnt", 32'(gnt), 0);
    chk("t5_drop_to", 32'(timeout), 0);
    tick();

    // 5b: done coincides with count expiry
    req = 8'b0100_0000;
    tick(); tick(); tick(); tick();
    chk("t5b_vld4", 32'(gnt_valid), 1);
    done = 1'b1;
    tick();
    done = 1'b0; req = '0;
    chk("t5b_gnt", 32'(gnt), 0);
    chk("t5b_to", 32'(timeout), 0);
    tick();

    // 6: async reset mid-grant, then RR from fresh state
    req = 8'b0001_0000;
    tick();
    chk("t6_pre_id", 32'(gnt_id), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 0);
    chk("t6_async_vld", 32'(gnt_valid), 0);
    chk("t6_async_to", 32'(timeout), 0);
    req = 8'b1000_0001; rr_mode = 1'b1;
    tick();
    chk("t6_held_vld", 32'(gnt_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_id", 32'(gnt_id), 7);
    chk("t6_gnt", 32'(gnt), 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
